// File: rtl/data_mem_responder.sv
// Load/store responder for the core's data-memory port: one request in flight, fixed access latency,
// byte/half/word accesses with sign/zero extension and alignment/range error reporting.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT     = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  CNT_INIT  = 4'(LATENCY - 1);
    localparam logic        SKIP_WAIT = (LATENCY == 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic [3:0]  cnt_r, cnt_s;
    logic        we_r, uns_r;
    logic [1:0]  size_r;
    logic [31:0] addr_r, wdata_r;
    logic        rsp_valid_r, rsp_err_r, busy_r;
    logic [31:0] rsp_rdata_r;
    logic [31:0] mem_r [DEPTH_WORDS];

    logic             accept_s, do_access_s, err_s, wr_en_s, rsp_done_s;
    logic             acc_we_s, acc_uns_s;
    logic [1:0]       acc_size_s;
    logic [31:0]      acc_addr_s, acc_wdata_s, off_s, rd_word_s, load_data_s, wdata_lanes_s;
    logic [IDX_W-1:0] word_idx_s;
    logic [3:0]       lane_mask_s;

    function automatic logic access_err(input logic [1:0] size, input logic [1:0] lane,
                                        input logic [31:0] off);
        logic e;
        case (size)
            2'b00:   e = 1'b0;
            2'b01:   e = lane[0];
            2'b10:   e = (lane != 2'b00);
            default: e = 1'b1;
        endcase
        return e || ({1'b0, off} >= LIMIT);
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] m;
        case (size)
            2'b00:   m = 4'b0001 << lane;
            2'b01:   m = lane[1] ? 4'b1100 : 4'b0011;
            2'b10:   m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Little-endian lane select followed by sign or zero extension
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic uns, input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
            2'b10:   r = word;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    assign accept_s   = req_valid && req_ready;
    assign rsp_done_s = (state_r == ST_RESP) && rsp_ready;

    // Access operands: live inputs when the access happens on the accepting edge, else the latched request
    always_comb begin
        acc_we_s    = we_r;
        acc_uns_s   = uns_r;
        acc_size_s  = size_r;
        acc_addr_s  = addr_r;
        acc_wdata_s = wdata_r;
        do_access_s = 1'b0;
        if (state_r == ST_IDLE) begin
            acc_we_s    = req_we;
            acc_uns_s   = req_unsigned;
            acc_size_s  = req_size;
            acc_addr_s  = req_addr;
            acc_wdata_s = req_wdata;
            do_access_s = accept_s && SKIP_WAIT;
        end else begin
            do_access_s = (state_r == ST_WAIT) && (cnt_r == 4'd0);
        end
    end

    assign off_s         = acc_addr_s - BASE_ADDR;
    assign err_s         = access_err(acc_size_s, acc_addr_s[1:0], off_s);
    assign word_idx_s    = off_s[IDX_W+1:2];
    assign rd_word_s     = mem_r[word_idx_s];
    assign wr_en_s       = do_access_s && acc_we_s && !err_s;
    assign lane_mask_s   = lane_mask(acc_size_s, acc_addr_s[1:0]);
    assign load_data_s   = acc_we_s ? 32'h0000_0000 : load_extend(rd_word_s, acc_size_s, acc_uns_s, acc_addr_s[1:0]);
    assign wdata_lanes_s = (acc_size_s == 2'b00) ? {4{acc_wdata_s[7:0]}} :
                           (acc_size_s == 2'b01) ? {2{acc_wdata_s[15:0]}} : acc_wdata_s;

    // Next-state and wait-counter logic
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    cnt_s = CNT_INIT;
                    if (SKIP_WAIT) begin
                        state_s = ST_RESP;
                    end else begin
                        state_s = ST_WAIT;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_s = ST_RESP;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State, counter and registered response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            rsp_valid_r <= (state_s == ST_RESP);
            busy_r      <= (state_s != ST_IDLE);
            if (do_access_s) begin
                rsp_rdata_r <= err_s ? 32'h0000_0000 : load_data_s;
                rsp_err_r   <= err_s;
            end else if (rsp_done_s) begin
                rsp_rdata_r <= 32'h0000_0000;
                rsp_err_r   <= 1'b0;
            end
        end
    end

    // Request capture on acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_r    <= 1'b0;
            uns_r   <= 1'b0;
            size_r  <= 2'b00;
            addr_r  <= 32'h0000_0000;
            wdata_r <= 32'h0000_0000;
        end else if (accept_s) begin
            we_r    <= req_we;
            uns_r   <= req_unsigned;
            size_r  <= req_size;
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
        end
    end

    // Array write: only the addressed lanes of a legal store; contents are never reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_mask_s[i]) begin
                    mem_r[word_idx_s][8*i +: 8] <= wdata_lanes_s[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = rst_n && (state_r == ST_IDLE);
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed + random bench for data_mem_responder: three instances (LATENCY 2, 1, 15) checked against
// a behavioural memory model through an expected-response queue.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid [3], req_ready [3], req_we [3], req_unsigned [3];
    logic        rsp_valid [3], rsp_ready [3], rsp_err [3], busy [3];
    logic [1:0]  req_size  [3];
    logic [31:0] req_addr  [3], req_wdata [3], rsp_rdata [3];

    int unsigned lat_tab   [3] = '{2, 1, 15};
    int unsigned depth_tab [3] = '{1024, 64, 64};
    logic [31:0] base_tab  [3] = '{32'h0000_1000, 32'h0000_2000, 32'h0000_0000};
    logic [31:0] ref_mem   [3][1024];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb [$];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_1000), .LATENCY(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .busy(busy[0]));

    data_mem_responder #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0000_2000), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .busy(busy[1]));

    data_mem_responder #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0000_0000), .LATENCY(15)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_we(req_we[2]),
        .req_size(req_size[2]), .req_unsigned(req_unsigned[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]), .busy(busy[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference memory model: returns the expected response and applies legal stores
    task automatic model(input int idx, input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err);
        logic [31:0] off, w;
        logic [7:0]  b;
        logic [15:0] h;
        int          wi, sh;
        off   = addr - base_tab[idx];
        err   = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00) ||
                ({1'b0, off} >= 33'(depth_tab[idx]) * 33'd4);
        rdata = 32'h0000_0000;
        if (!err) begin
            wi = int'(off[31:2]);
            sh = 8 * int'(addr[1:0]);
            w  = ref_mem[idx][wi];
            if (we) begin
                if (size == 2'b00) w[sh +: 8] = wdata[7:0];
                else if (size == 2'b01) w[sh +: 16] = wdata[15:0];
                else w = wdata;
                ref_mem[idx][wi] = w;
            end else begin
                b = w[sh +: 8];
                h = w[sh +: 16];
                if (size == 2'b00) rdata = uns ? {24'h000000, b} : {{24{b[7]}}, b};
                else if (size == 2'b01) rdata = uns ? {16'h0000, h} : {{16{h[15]}}, h};
                else rdata = w;
            end
        end
    endtask

    // One complete transaction: issue, track latency, compare response, optional back-pressure
    task automatic do_req(input int idx, input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input int hold);
        exp_t        e;
        int          lat;
        logic [31:0] held;
        @(negedge clk);
        check("req_ready_idle", 32'(req_ready[idx]), 32'd1);
        req_we[idx] = we; req_size[idx] = size; req_unsigned[idx] = uns;
        req_addr[idx] = addr; req_wdata[idx] = wdata; req_valid[idx] = 1'b1;
        model(idx, we, size, uns, addr, wdata, e.rdata, e.err);
        e.lat = (lat_tab[idx] == 1) ? 0 : int'(lat_tab[idx]);
        sb.push_back(e);
        @(posedge clk);
        #1 req_valid[idx] = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!rsp_valid[idx] && lat < 40) begin
            check("busy_wait", {30'd0, busy[idx], req_ready[idx]}, 32'd2);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("rsp_valid_timeout", 32'(rsp_valid[idx]), 32'd1);
        e = sb.pop_front();
        check("rsp_latency", 32'(lat), 32'(e.lat));
        check("rsp_rdata", rsp_rdata[idx], e.rdata);
        check("rsp_err", 32'(rsp_err[idx]), 32'(e.err));
        held = rsp_rdata[idx];
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_valid_ready", {30'd0, rsp_valid[idx], req_ready[idx]}, 32'd2);
            check("hold_rdata", rsp_rdata[idx], held);
        end
        rsp_ready[idx] = 1'b1;
        @(posedge clk);
        #1 rsp_ready[idx] = 1'b0;
        @(negedge clk);
        check("post_handshake", {30'd0, rsp_valid[idx], req_ready[idx]}, 32'd1);
    endtask

    task automatic rand_traffic(input int idx, input int n);
        logic [31:0] addr;
        int          sel;
        for (int w = 0; w < 8; w++) do_req(idx, 1'b1, 2'b10, 1'b0, base_tab[idx] + 32'(4 * w), $urandom, 0);
        for (int i = 0; i < n; i++) begin
            sel  = int'($urandom_range(0, 9));
            addr = base_tab[idx] + 32'($urandom_range(0, 31));
            if (sel == 0) addr = base_tab[idx] + 32'(depth_tab[idx] * 4) + 32'($urandom_range(0, 7));
            if (sel == 1) addr = base_tab[idx] - 32'd4;
            do_req(idx, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   addr, $urandom, int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        logic [31:0] b0;
        for (int i = 0; i < 3; i++) begin
            req_valid[i] = 1'b0; req_we[i] = 1'b0; req_size[i] = 2'b00; req_unsigned[i] = 1'b0;
            req_addr[i] = 32'd0; req_wdata[i] = 32'd0; rsp_ready[i] = 1'b0;
        end
        rst_n = 1'b0;
        #23;
        for (int i = 0; i < 3; i++) begin
            check("reset_ready", 32'(req_ready[i]), 32'd0);
            check("reset_valid_busy_err", {29'd0, rsp_valid[i], busy[i], rsp_err[i]}, 32'd0);
            check("reset_rdata", rsp_rdata[i], 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        b0 = base_tab[0];
        // Word store then load
        do_req(0, 1'b1, 2'b10, 1'b0, b0 + 32'd8, 32'hDEAD_BEEF, 0);
        do_req(0, 1'b0, 2'b10, 1'b0, b0 + 32'd8, 32'd0, 0);
        // Byte store into a known word, signed/unsigned reloads, neighbouring lanes
        do_req(0, 1'b1, 2'b10, 1'b0, b0 + 32'd4, 32'h1122_3344, 0);
        do_req(0, 1'b1, 2'b00, 1'b0, b0 + 32'd5, 32'h0000_0080, 0);
        do_req(0, 1'b0, 2'b00, 1'b0, b0 + 32'd5, 32'd0, 0);
        do_req(0, 1'b0, 2'b00, 1'b1, b0 + 32'd5, 32'd0, 0);
        do_req(0, 1'b0, 2'b10, 1'b0, b0 + 32'd4, 32'd0, 0);
        do_req(0, 1'b0, 2'b01, 1'b0, b0 + 32'd6, 32'd0, 0);
        // Error cases, then confirm the array is untouched
        do_req(0, 1'b0, 2'b01, 1'b0, b0 + 32'd3, 32'd0, 0);
        do_req(0, 1'b0, 2'b10, 1'b0, b0 + 32'd2, 32'd0, 0);
        do_req(0, 1'b1, 2'b11, 1'b0, b0 + 32'd8, 32'h5555_5555, 0);
        do_req(0, 1'b1, 2'b10, 1'b0, b0 + 32'd4096, 32'h6666_6666, 0);
        do_req(0, 1'b1, 2'b10, 1'b0, b0 - 32'd4, 32'h7777_7777, 0);
        do_req(0, 1'b1, 2'b10, 1'b0, b0 + 32'd4092, 32'hCAFE_F00D, 0);
        do_req(0, 1'b0, 2'b10, 1'b0, b0 + 32'd4092, 32'd0, 0);
        do_req(0, 1'b0, 2'b10, 1'b0, b0 + 32'd8, 32'd0, 0);
        // Back-pressure: response held for 5 cycles
        do_req(0, 1'b0, 2'b10, 1'b0, b0 + 32'd4, 32'd0, 5);

        // Reset during WAIT of a store: write must never land
        do_req(0, 1'b1, 2'b10, 1'b0, b0, 32'h0000_0000, 0);
        @(negedge clk);
        req_we[0] = 1'b1; req_size[0] = 2'b10; req_addr[0] = b0; req_wdata[0] = 32'h1234_5678; req_valid[0] = 1'b1;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(negedge clk);
        check("wait_before_reset", 32'(busy[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midop_reset_ready", 32'(req_ready[0]), 32'd0);
        check("midop_reset_valid_busy_err", {29'd0, rsp_valid[0], busy[0], rsp_err[0]}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_req(0, 1'b0, 2'b10, 1'b0, b0, 32'd0, 0);

        // Latency extremes with random legal and illegal traffic
        rand_traffic(1, 60);
        rand_traffic(2, 25);
        rand_traffic(0, 20);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
